// File: rtl/alarm_if.sv
// Alarm scheduler bus: time feed, entry writes, user buttons and status outputs.
interface alarm_if;
    logic        tick;
    logic [19:0] cur_time;
    logic        wr_en;
    logic [1:0]  wr_id;
    logic [19:0] wr_time;
    logic        wr_enable;
    logic        snooze;
    logic        dismiss;
    logic        ring;
    logic        snoozing;
    logic [1:0]  active_id;
    logic [3:0]  pending;
    logic [3:0]  alarm_en;
    logic        missed;

    // Driver side: time source, alarm editor and buttons.
    modport master (
        output tick, cur_time, wr_en, wr_id, wr_time, wr_enable, snooze, dismiss,
        input  ring, snoozing, active_id, pending, alarm_en, missed
    );

    // Scheduler side.
    modport slave (
        input  tick, cur_time, wr_en, wr_id, wr_time, wr_enable, snooze, dismiss,
        output ring, snoozing, active_id, pending, alarm_en, missed
    );
endinterface

// File: rtl/alarm_scheduler.sv
// Four-entry alarm store with ring / snooze / timeout sequencing and a
// pending queue for alarms that match while another one is being serviced.
module alarm_scheduler #(
    parameter int SNOOZE_SEC   = 300,
    parameter int RING_TIMEOUT = 60,
    parameter int MAX_SNOOZE   = 3
) (
    input  logic   clk,
    input  logic   rst,
    alarm_if.slave bus
);
    localparam int              USED_W    = $clog2(MAX_SNOOZE + 1);
    localparam logic [8:0]      RING_LOAD = 9'(RING_TIMEOUT);
    localparam logic [8:0]      SNZ_LOAD  = 9'(SNOOZE_SEC);
    localparam logic [USED_W-1:0] USED_MAX = USED_W'(MAX_SNOOZE);

    typedef enum logic [1:0] {S_IDLE, S_RINGING, S_SNOOZE} state_t;

    logic [19:0]       alarm_time [4];
    logic [3:0]        enable_q;
    logic [3:0]        match, match_q, event_w;
    logic [3:0]        pending_q, pending_d, clr_mask;
    logic [1:0]        pick_id;
    state_t            state_q, state_d;
    logic [8:0]        ring_cnt_q, ring_cnt_d;
    logic [8:0]        snz_cnt_q, snz_cnt_d;
    logic [USED_W-1:0] used_q, used_d;
    logic [1:0]        active_q, active_d;
    logic              missed_q, missed_d;
    logic              kill;

    // Alarm entry store; writes accepted in every state.
    // NOTE: the entry array is reset explicitly because a stale enabled entry
    // would fire after reset; that costs flops instead of plain RAM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) alarm_time[i] <= '0;
            enable_q <= '0;
        end else if (bus.wr_en) begin
            alarm_time[bus.wr_id] <= bus.wr_time;
            enable_q[bus.wr_id]   <= bus.wr_enable;
        end
    end

    // Full 20-bit compare of each enabled entry against live time.
    always_comb begin
        for (int i = 0; i < 4; i++)
            match[i] = enable_q[i] && (alarm_time[i] == bus.cur_time);
    end

    // One event per matching second: rising edge of the match vector.
    assign event_w = match & ~match_q;

    // Lowest pending index wins service.
    always_comb begin
        pick_id = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (pending_q[i]) pick_id = 2'(i);
    end

    // Writing enable=0 to the serviced entry aborts it silently.
    assign kill = bus.wr_en && !bus.wr_enable && (bus.wr_id == active_q);

    // Next-state and counter logic for the ringing controller.
    // NOTE: every combinational output gets a default first so no path
    // through the case statement can leave a latch behind.
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        used_d     = used_q;
        active_d   = active_q;
        missed_d   = 1'b0;
        clr_mask   = 4'b0000;
        case (state_q)
            S_IDLE: begin
                if (pending_q != 4'b0000) begin
                    state_d    = S_RINGING;
                    active_d   = pick_id;
                    clr_mask   = 4'b0001 << pick_id;
                    ring_cnt_d = RING_LOAD;
                    used_d     = '0;
                end
            end
            S_RINGING: begin
                if (kill || bus.dismiss) begin
                    state_d = S_IDLE;
                end else if (bus.snooze) begin
                    if (used_q < USED_MAX) begin
                        state_d   = S_SNOOZE;
                        snz_cnt_d = SNZ_LOAD;
                        used_d    = used_q + 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (bus.tick) begin
                    if (ring_cnt_q == 9'd1) begin
                        state_d  = S_IDLE;
                        missed_d = 1'b1;
                    end else begin
                        ring_cnt_d = ring_cnt_q - 9'd1;
                    end
                end
            end
            S_SNOOZE: begin
                if (kill || bus.dismiss) begin
                    state_d = S_IDLE;
                end else if (bus.tick) begin
                    if (snz_cnt_q == 9'd1) begin
                        state_d    = S_RINGING;
                        ring_cnt_d = RING_LOAD;
                    end else begin
                        snz_cnt_d = snz_cnt_q - 9'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Serviced bit drops, new events queue, disabled entries leave the queue.
        pending_d = ((pending_q & ~clr_mask) | event_w) & enable_q;
    end

    // Controller state, counters, queue and match history.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            used_q     <= '0;
            active_q   <= '0;
            missed_q   <= 1'b0;
            pending_q  <= '0;
            match_q    <= '0;
        end else begin
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            used_q     <= used_d;
            active_q   <= active_d;
            missed_q   <= missed_d;
            pending_q  <= pending_d;
            match_q    <= match;
        end
    end

    assign bus.ring      = (state_q == S_RINGING);
    assign bus.snoozing  = (state_q == S_SNOOZE);
    assign bus.active_id = active_q;
    assign bus.pending   = pending_q;
    assign bus.alarm_en  = enable_q;
    assign bus.missed    = missed_q;
endmodule

// File: tb/tb_alarm_scheduler.sv
// Directed bench for alarm_scheduler: a vector table for match, timeout and
// queueing, plus hand sequences for snooze limits, aborts and async reset.
module tb_alarm_scheduler;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_total = 0;
    int   n_pass  = 0;

    alarm_if bus ();

    alarm_scheduler #(.SNOOZE_SEC(2), .RING_TIMEOUT(3), .MAX_SNOOZE(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        tick;
        logic [19:0] cur_time;
        logic        wr_en;
        logic [1:0]  wr_id;
        logic [19:0] wr_time;
        logic        wr_enable;
        logic        snooze;
        logic        dismiss;
        logic        e_ring;
        logic        e_snoozing;
        logic [1:0]  e_active;
        logic [3:0]  e_pending;
        logic [3:0]  e_alarm_en;
        logic        e_missed;
    } vec_t;

    localparam int NVEC = 15;
    vec_t vecs [NVEC];

    function automatic logic [19:0] bcd(input int hh, input int mm, input int ss);
        logic [1:0] h1; logic [3:0] h0; logic [2:0] m1; logic [3:0] m0;
        logic [2:0] s1; logic [3:0] s0;
        h1 = 2'(hh / 10); h0 = 4'(hh % 10);
        m1 = 3'(mm / 10); m0 = 4'(mm % 10);
        s1 = 3'(ss / 10); s0 = 4'(ss % 10);
        return {h1, h0, m1, m0, s1, s0};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.tick = 1'b0; bus.wr_en = 1'b0; bus.wr_id = 2'd0; bus.wr_time = '0;
        bus.wr_enable = 1'b0; bus.snooze = 1'b0; bus.dismiss = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic e_ring, input logic e_snz,
                               input logic [3:0] e_pend, input logic e_missed);
        check({tag, " ring"},     32'(bus.ring),     32'(e_ring));
        check({tag, " snoozing"}, 32'(bus.snoozing), 32'(e_snz));
        check({tag, " pending"},  32'(bus.pending),  32'(e_pend));
        check({tag, " missed"},   32'(bus.missed),   32'(e_missed));
    endtask

    logic [19:0] t0729, t0730, t0759, t0800;

    initial begin
        t0729 = bcd(7, 29, 59);
        t0730 = bcd(7, 30, 0);
        t0759 = bcd(7, 59, 59);
        t0800 = bcd(8, 0, 0);

        //            tick cur   wr  id   wr_time en snz dis | ring snz act pend    aen     miss
        vecs[0]  = '{1'b0, t0729, 1'b1, 2'd2, t0730, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0000, 4'b0100, 1'b0};
        vecs[1]  = '{1'b0, t0730, 1'b0, 2'd0, 20'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 4'b0100, 4'b0100, 1'b0};
        vecs[2]  = '{1'b0, t0730, 1'b0, 2'd0, 20'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 4'b0000, 4'b0100, 1'b0};
        vecs[3]  = '{1'b0, t0730, 1'b0, 2'd0, 20'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 4'b0000, 4'b0100, 1'b0};
        vecs[4]  = '{1'b1, t0730, 1'b0, 2'd0, 20'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 4'b0000, 4'b0100, 1'b0};
        vecs[5]  = '{1'b1, t0730, 1'b0, 2'd0, 20'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 4'b0000, 4'b0100, 1'b0};
        vecs[6]  = '{1'b1, t0730, 1'b0, 2'd0, 20'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0000, 4'b0100, 1'b1};
        vecs[7]  = '{1'b0, t0730, 1'b0, 2'd0, 20'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0000, 4'b0100, 1'b0};
        vecs[8]  = '{1'b0, t0759, 1'b1, 2'd1, t0800, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0000, 4'b0110, 1'b0};
        vecs[9]  = '{1'b0, t0759, 1'b1, 2'd3, t0800, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b0000, 4'b1110, 1'b0};
        vecs[10] = '{1'b0, t0800, 1'b0, 2'd0, 20'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 4'b1010, 4'b1110, 1'b0};
        vecs[11] = '{1'b0, t0800, 1'b0, 2'd0, 20'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 4'b1000, 4'b1110, 1'b0};
        vecs[12] = '{1'b0, t0800, 1'b0, 2'd0, 20'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 4'b1000, 4'b1110, 1'b0};
        vecs[13] = '{1'b0, t0800, 1'b0, 2'd0, 20'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 4'b0000, 4'b1110, 1'b0};
        vecs[14] = '{1'b0, t0800, 1'b0, 2'd0, 20'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 4'b1110, 1'b0};

        idle_inputs();
        bus.cur_time = '0;

        // Reset state
        #12;
        check("rst ring",     32'(bus.ring),      32'd0);
        check("rst snoozing", 32'(bus.snoozing),  32'd0);
        check("rst active",   32'(bus.active_id), 32'd0);
        check("rst pending",  32'(bus.pending),   32'd0);
        check("rst alarm_en", 32'(bus.alarm_en),  32'd0);
        check("rst missed",   32'(bus.missed),    32'd0);
        @(negedge clk);
        rst = 1'b0;
        cycle();

        // Table: match latency, no re-fire, timeout, simultaneous queueing
        for (int i = 0; i < NVEC; i++) begin
            bus.tick = vecs[i].tick;       bus.cur_time  = vecs[i].cur_time;
            bus.wr_en = vecs[i].wr_en;     bus.wr_id     = vecs[i].wr_id;
            bus.wr_time = vecs[i].wr_time; bus.wr_enable = vecs[i].wr_enable;
            bus.snooze = vecs[i].snooze;   bus.dismiss   = vecs[i].dismiss;
            cycle();
            check($sformatf("v%0d ring", i),     32'(bus.ring),      32'(vecs[i].e_ring));
            check($sformatf("v%0d snoozing", i), 32'(bus.snoozing),  32'(vecs[i].e_snoozing));
            check($sformatf("v%0d active", i),   32'(bus.active_id), 32'(vecs[i].e_active));
            check($sformatf("v%0d pending", i),  32'(bus.pending),   32'(vecs[i].e_pending));
            check($sformatf("v%0d alarm_en", i), 32'(bus.alarm_en),  32'(vecs[i].e_alarm_en));
            check($sformatf("v%0d missed", i),   32'(bus.missed),    32'(vecs[i].e_missed));
        end
        idle_inputs();

        // Snooze three times, the fourth snooze acts as dismiss
        bus.cur_time = t0730;
        cycle();
        check_state("snz queue", 1'b0, 1'b0, 4'b0100, 1'b0);
        cycle();
        check_state("snz ring", 1'b1, 1'b0, 4'b0000, 1'b0);
        check("snz active", 32'(bus.active_id), 32'd2);
        for (int n = 1; n <= 3; n++) begin
            bus.snooze = 1'b1; cycle(); bus.snooze = 1'b0;
            check_state($sformatf("snz%0d enter", n), 1'b0, 1'b1, 4'b0000, 1'b0);
            bus.tick = 1'b1; cycle();
            check_state($sformatf("snz%0d tick1", n), 1'b0, 1'b1, 4'b0000, 1'b0);
            cycle(); bus.tick = 1'b0;
            check_state($sformatf("snz%0d rering", n), 1'b1, 1'b0, 4'b0000, 1'b0);
            check($sformatf("snz%0d active", n), 32'(bus.active_id), 32'd2);
        end
        bus.snooze = 1'b1; cycle(); bus.snooze = 1'b0;
        check_state("snz4 dismiss", 1'b0, 1'b0, 4'b0000, 1'b0);

        // Snooze and dismiss together: dismiss wins
        bus.cur_time = t0729; cycle();
        bus.cur_time = t0730; cycle(); cycle();
        check_state("both ring", 1'b1, 1'b0, 4'b0000, 1'b0);
        bus.snooze = 1'b1; bus.dismiss = 1'b1; cycle(); idle_inputs();
        check_state("both idle", 1'b0, 1'b0, 4'b0000, 1'b0);

        // Disable the snoozed entry: silent return to IDLE
        bus.cur_time = t0729; cycle();
        bus.cur_time = t0730; cycle(); cycle();
        bus.snooze = 1'b1; cycle(); bus.snooze = 1'b0;
        check_state("kill snoozing", 1'b0, 1'b1, 4'b0000, 1'b0);
        bus.wr_en = 1'b1; bus.wr_id = 2'd2; bus.wr_time = t0730; bus.wr_enable = 1'b0;
        cycle(); idle_inputs();
        check_state("kill idle", 1'b0, 1'b0, 4'b0000, 1'b0);
        check("kill alarm_en", 32'(bus.alarm_en), 32'b1010);
        cycle();
        check_state("kill after", 1'b0, 1'b0, 4'b0000, 1'b0);

        // Re-enable while time already matches, then async reset mid-ring
        bus.wr_en = 1'b1; bus.wr_id = 2'd2; bus.wr_time = t0730; bus.wr_enable = 1'b1;
        cycle(); idle_inputs();
        cycle();
        check_state("reen queue", 1'b0, 1'b0, 4'b0100, 1'b0);
        cycle();
        check_state("reen ring", 1'b1, 1'b0, 4'b0000, 1'b0);
        #2 rst = 1'b1;
        #1;
        check_state("async rst", 1'b0, 1'b0, 4'b0000, 1'b0);
        check("async alarm_en", 32'(bus.alarm_en),  32'd0);
        check("async active",   32'(bus.active_id), 32'd0);
        cycle();
        #3 rst = 1'b0;
        bus.cur_time = '0;
        cycle(); cycle(); cycle();
        check_state("post rst", 1'b0, 1'b0, 4'b0000, 1'b0);
        check("post alarm_en", 32'(bus.alarm_en), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/alarm_scheduler.md
Name: alarm_scheduler

Overview:
Four-entry alarm store and ringing controller for the digital clock. It watches the live packed-BCD time from the time counters and raises ring when an enabled alarm matches. It sequences ringing, snooze, timeout and dismissal, and queues alarms that match while another is being serviced. It sits beside the time view and drives the buzzer/LED output and the alarm status display.

Parameters:
SNOOZE_SEC, 300, snooze length in tick pulses (1..511).
RING_TIMEOUT, 60, ringing length in ticks before auto-stop (1..511).
MAX_SNOOZE, 3, snoozes allowed per alarm event; a further snooze acts as dismiss.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
tick  in  1  one-cycle pulse per second, from the second divider
cur_time  in  20  live time, 24h packed BCD: h1[19:18] h0[17:14] m1[13:11] m0[10:7] s1[6:4] s0[3:0]
wr_en  in  1  write strobe for one alarm entry
wr_id  in  2  entry index written
wr_time  in  20  alarm time, same packing as cur_time
wr_enable  in  1  enable bit stored with the entry
snooze  in  1  snooze request, level sampled each clk
dismiss  in  1  dismiss request, level sampled each clk
ring  out  1  buzzer drive
snoozing  out  1  high in SNOOZE state
active_id  out  2  entry currently ringing or snoozed
pending  out  4  queued matched entries
alarm_en  out  4  stored enable bits
missed  out  1  one-cycle pulse when ringing ends by timeout

Behaviour:
- Reset (async, immediate): all entries time=0, enable=0; state IDLE; ring=0, snoozing=0, active_id=0, pending=0, missed=0, all counters 0, match history 0.
- Write: on clk edge with wr_en=1, entry[wr_id] <= {wr_time, wr_enable}. alarm_en reflects it the next cycle. Writes are accepted in any state.
- Match detection: match[i] = enable[i] && (time[i] == cur_time), all 20 bits compared. Register match_q each cycle. An event for entry i is match[i] && !match_q[i] (rising edge). This fires once per matching second; it never re-fires while cur_time holds.
- Each event sets pending[i] on the next edge. Entries with an event in the same cycle all set.
- IDLE: if pending != 0, pick the lowest set index k. Next edge: state RINGING, active_id=k, clear pending[k], ring_cnt=RING_TIMEOUT, snooze_used=0. ring=1 from that edge onward, so event-to-ring latency is 2 cycles.
- RINGING, priority highest first:
  - dismiss=1: go to IDLE, ring=0. Dismiss wins over a simultaneous snooze.
  - snooze=1 and snooze_used<MAX_SNOOZE: go to SNOOZE, snz_cnt=SNOOZE_SEC, snooze_used+1, ring=0.
  - snooze=1 and snooze_used==MAX_SNOOZE: treated as dismiss.
  - tick=1 and ring_cnt==1: go to IDLE, pulse missed for 1 cycle.
  - tick=1 otherwise: ring_cnt-1.
- SNOOZE, priority highest first:
  - dismiss=1: go to IDLE.
  - tick=1 and snz_cnt==1: go to RINGING, same active_id, ring_cnt reloaded to RING_TIMEOUT.
  - tick=1 otherwise: snz_cnt-1.
  - snooze input is ignored in this state.
- A write with wr_enable=0 to active_id while in RINGING or SNOOZE: go to IDLE next edge, no missed pulse. Writing a new time with enable=1 does not disturb the ring in progress.
- Events during RINGING/SNOOZE only set pending; they are serviced on return to IDLE, one per IDLE cycle, lowest index first. A new event for active_id itself also queues.
- A pending bit whose entry becomes disabled before service is cleared on the next edge.
- snoozing=1 exactly in SNOOZE. active_id holds its last value in IDLE.
- Counters are 9 bits wide with no wrap. The decision logic uses only the ==1 comparisons above.

Test Plan:
- Reset then write entry 2 = 07:30:00, enabled; drive cur_time 07:29:59 -> 07:30:00 -> ring=1 two cycles after the change, active_id=2, pending=0; holding cur_time produces no second event.
- Ring with RING_TIMEOUT=3, send 3 ticks, no button -> missed pulses once on the 3rd tick, ring=0, state IDLE.
- Ringing, assert snooze with SNOOZE_SEC=2 -> snoozing=1, ring=0; after 2 ticks ring=1 again. Repeat until snooze_used=3; the 4th snooze drops ring to 0 and does not enter SNOOZE.
- Entries 1 and 3 set to the same time -> pending=1010 then ring with active_id=1, pending=1000; dismiss -> next IDLE cycle ring restarts with active_id=3.
- While ringing, assert snooze and dismiss in the same cycle -> IDLE, snoozing stays 0. While snoozing, write entry active_id with wr_enable=0 -> IDLE, no missed pulse.
- Assert rst mid-RINGING, asynchronous to clk -> ring, pending and alarm_en go to 0 immediately; after release, a time match produces no event.
